// File: rtl/io_store_rmw_unit_if.sv
// Store-request, IO read/write bus and completion signals of io_store_rmw_unit.
// master: the RMW unit side; slave: the pipeline/bus environment side.
interface io_store_rmw_unit_if #(
  parameter int unsigned DATABITWIDTH = 16,
  parameter int unsigned ADDRBITWIDTH = 16
);
  logic                    store_req_valid;
  logic                    store_req_ready;
  logic [3:0]              store_minor_opcode;
  logic [ADDRBITWIDTH-1:0] store_addr;
  logic [DATABITWIDTH-1:0] store_data;
  logic                    io_rd_valid;
  logic                    io_rd_ready;
  logic [ADDRBITWIDTH-1:0] io_rd_addr;
  logic                    io_rd_resp_valid;
  logic [DATABITWIDTH-1:0] io_rd_resp_data;
  logic                    io_wr_valid;
  logic                    io_wr_ready;
  logic [ADDRBITWIDTH-1:0] io_wr_addr;
  logic [DATABITWIDTH-1:0] io_wr_data;
  logic                    store_done;
  logic                    store_error;

  modport master (
    input  store_req_valid, store_minor_opcode, store_addr, store_data,
           io_rd_ready, io_rd_resp_valid, io_rd_resp_data, io_wr_ready,
    output store_req_ready, io_rd_valid, io_rd_addr, io_wr_valid,
           io_wr_addr, io_wr_data, store_done, store_error
  );

  modport slave (
    output store_req_valid, store_minor_opcode, store_addr, store_data,
           io_rd_ready, io_rd_resp_valid, io_rd_resp_data, io_wr_ready,
    input  store_req_ready, io_rd_valid, io_rd_addr, io_wr_valid,
           io_wr_addr, io_wr_data, store_done, store_error
  );
endinterface

// File: rtl/io_store_rmw_unit.sv
// Sequential read-modify-write engine for sub-word IO stores.
// Optional: IO_STORE_FULLWIDTH_BYPASS_EN skips the read for full-width stores.
module io_store_rmw_unit #(
  parameter int unsigned DATABITWIDTH = 16,
  parameter int unsigned ADDRBITWIDTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  io_store_rmw_unit_if.master bus
);
  localparam int unsigned NBYTES = DATABITWIDTH / 8;
  localparam logic [ADDRBITWIDTH-1:0] OFFMASK = ADDRBITWIDTH'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, DONE, ERR} stateT;
  stateT state;

  logic [ADDRBITWIDTH-1:0] rdAddr, wrAddr, reqWordAddr;
  logic [DATABITWIDTH-1:0] capData, wrData, mergedWord, shiftedData;
  logic [3:0]              capOffset, capSizeBytes, reqOffset, reqSizeBytes;
  logic                    reqReady, rdValid, wrValid, doneReg, errReg;
  logic                    reqIllegal;
  logic [1:0]              unusedOpBits;
`ifdef IO_STORE_FULLWIDTH_BYPASS_EN
  logic                    reqFull;
  assign reqFull = (32'(reqSizeBytes) == NBYTES);
`endif

  assign unusedOpBits = bus.store_minor_opcode[3:2];
  assign reqSizeBytes = 4'd1 << bus.store_minor_opcode[1:0];
  assign reqOffset    = 4'(bus.store_addr & OFFMASK);
  assign reqWordAddr  = bus.store_addr & ~OFFMASK;
  // Oversize takes precedence over misalignment; both end in ERR without bus traffic.
  assign reqIllegal   = (32'(reqSizeBytes) > NBYTES) ||
                        ((reqOffset & (reqSizeBytes - 4'd1)) != 4'd0);

  assign shiftedData = capData << (32'(capOffset) * 8);

  always_comb begin
    mergedWord = bus.io_rd_resp_data;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (i >= 32'(capOffset) && i < 32'(capOffset) + 32'(capSizeBytes))
        mergedWord[i*8 +: 8] = shiftedData[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      reqReady     <= 1'b1;
      rdValid      <= 1'b0;
      wrValid      <= 1'b0;
      doneReg      <= 1'b0;
      errReg       <= 1'b0;
      rdAddr       <= '0;
      wrAddr       <= '0;
      wrData       <= '0;
      capData      <= '0;
      capOffset    <= '0;
      capSizeBytes <= '0;
    end else begin
      doneReg <= 1'b0;
      errReg  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.store_req_valid) begin
            reqReady     <= 1'b0;
            capData      <= bus.store_data;
            capOffset    <= reqOffset;
            capSizeBytes <= reqSizeBytes;
            if (reqIllegal) begin
              state   <= ERR;
              doneReg <= 1'b1;
              errReg  <= 1'b1;
            end
`ifdef IO_STORE_FULLWIDTH_BYPASS_EN
            else if (reqFull) begin
              state   <= WR;
              wrValid <= 1'b1;
              wrAddr  <= reqWordAddr;
              wrData  <= bus.store_data;
            end
`endif
            else begin
              state   <= RD_REQ;
              rdValid <= 1'b1;
              rdAddr  <= reqWordAddr;
              wrAddr  <= reqWordAddr;
            end
          end
        end
        RD_REQ: begin
          if (bus.io_rd_ready) begin
            rdValid <= 1'b0;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.io_rd_resp_valid) begin
            wrData  <= mergedWord;
            wrValid <= 1'b1;
            state   <= WR;
          end
        end
        WR: begin
          if (bus.io_wr_ready) begin
            wrValid <= 1'b0;
            doneReg <= 1'b1;
            state   <= DONE;
          end
        end
        DONE, ERR: begin
          reqReady <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          reqReady <= 1'b1;
          rdValid  <= 1'b0;
          wrValid  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.store_req_ready = reqReady;
  assign bus.io_rd_valid     = rdValid;
  assign bus.io_rd_addr      = rdAddr;
  assign bus.io_wr_valid     = wrValid;
  assign bus.io_wr_addr      = wrAddr;
  assign bus.io_wr_data      = wrData;
  assign bus.store_done      = doneReg;
  assign bus.store_error     = errReg;
endmodule

// File: tb/tb_io_store_rmw_unit.sv
// Directed bench for io_store_rmw_unit on 32-, 64- and 16-bit buses.
module tb_io_store_rmw_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  io_store_rmw_unit_if #(.DATABITWIDTH(32), .ADDRBITWIDTH(16)) b32 ();
  io_store_rmw_unit_if #(.DATABITWIDTH(64), .ADDRBITWIDTH(16)) b64 ();
  io_store_rmw_unit_if #(.DATABITWIDTH(16), .ADDRBITWIDTH(16)) b16 ();

  io_store_rmw_unit #(.DATABITWIDTH(32), .ADDRBITWIDTH(16)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  io_store_rmw_unit #(.DATABITWIDTH(64), .ADDRBITWIDTH(16)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));
  io_store_rmw_unit #(.DATABITWIDTH(16), .ADDRBITWIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    totalCnt++; if ({b32.store_req_ready, b32.io_rd_valid, b32.io_wr_valid, b32.store_done, b32.store_error} !== 5'b10000)
      $display("FAIL reset_ctrl32 got %b want 10000", {b32.store_req_ready, b32.io_rd_valid, b32.io_wr_valid, b32.store_done, b32.store_error}); else passCnt++;
    totalCnt++; if ({b32.io_rd_addr, b32.io_wr_addr, b32.io_wr_data} !== 64'h0)
      $display("FAIL reset_data32 got %h want 0", {b32.io_rd_addr, b32.io_wr_addr, b32.io_wr_data}); else passCnt++;
    rst_n = 1'b1;
    cyc;
    totalCnt++; if ({b64.store_req_ready, b64.io_rd_valid, b64.io_wr_valid, b16.store_req_ready, b16.store_done} !== 5'b10010)
      $display("FAIL reset_other got %b want 10010", {b64.store_req_ready, b64.io_rd_valid, b64.io_wr_valid, b16.store_req_ready, b16.store_done}); else passCnt++;
  endtask

  task automatic test_byte_rmw;
    b32.io_rd_ready = 1'b1; b32.io_wr_ready = 1'b1;
    cyc; b32.store_req_valid = 1'b1; b32.store_minor_opcode = 4'd0; b32.store_addr = 16'h0006; b32.store_data = 32'h000000AB;
    cyc; b32.store_req_valid = 1'b0;
    totalCnt++; if ({b32.io_rd_valid, b32.io_rd_addr, b32.store_req_ready} !== {1'b1, 16'h0004, 1'b0})
      $display("FAIL byte_rd_req got %b/%h/%b want 1/0004/0", b32.io_rd_valid, b32.io_rd_addr, b32.store_req_ready); else passCnt++;
    cyc;
    totalCnt++; if (b32.io_rd_valid !== 1'b0) $display("FAIL byte_rd_drop got %b want 0", b32.io_rd_valid); else passCnt++;
    b32.io_rd_resp_valid = 1'b1; b32.io_rd_resp_data = 32'h11223344;
    cyc; b32.io_rd_resp_valid = 1'b0;
    totalCnt++; if ({b32.io_wr_valid, b32.io_wr_addr, b32.io_wr_data} !== {1'b1, 16'h0004, 32'h11AB3344})
      $display("FAIL byte_wr got %b/%h/%h want 1/0004/11ab3344", b32.io_wr_valid, b32.io_wr_addr, b32.io_wr_data); else passCnt++;
    cyc;
    totalCnt++; if ({b32.store_done, b32.store_error, b32.io_wr_valid} !== 3'b100)
      $display("FAIL byte_done_c4 got %b want 100", {b32.store_done, b32.store_error, b32.io_wr_valid}); else passCnt++;
    cyc;
    totalCnt++; if ({b32.store_done, b32.store_req_ready} !== 2'b01)
      $display("FAIL byte_idle got %b want 01", {b32.store_done, b32.store_req_ready}); else passCnt++;
  endtask

  task automatic test_word_back_to_back;
    cyc; b32.store_req_valid = 1'b1; b32.store_minor_opcode = 4'b1101; b32.store_addr = 16'h0002; b32.store_data = 32'h0000BEEF;
    cyc; b32.store_req_valid = 1'b0;
    totalCnt++; if (b32.io_rd_valid !== 1'b1) $display("FAIL word_rd_valid got %b want 1", b32.io_rd_valid); else passCnt++;
    cyc; b32.io_rd_resp_valid = 1'b1; b32.io_rd_resp_data = 32'hCAFEF00D;
    cyc; b32.io_rd_resp_valid = 1'b0;
    totalCnt++; if (b32.io_wr_data !== 32'hBEEFF00D) $display("FAIL word_wr_data got %h want beeff00d", b32.io_wr_data); else passCnt++;
    cyc;
    totalCnt++; if ({b32.store_done, b32.store_error} !== 2'b10) $display("FAIL word_done got %b want 10", {b32.store_done, b32.store_error}); else passCnt++;
    b32.store_req_valid = 1'b1; b32.store_minor_opcode = 4'd0; b32.store_addr = 16'h0000; b32.store_data = 32'h0000005C;
    cyc;
    totalCnt++; if ({b32.store_req_ready, b32.io_rd_valid, b32.store_done} !== 3'b100)
      $display("FAIL b2b_ready got %b want 100", {b32.store_req_ready, b32.io_rd_valid, b32.store_done}); else passCnt++;
    cyc; b32.store_req_valid = 1'b0;
    totalCnt++; if ({b32.io_rd_valid, b32.io_rd_addr} !== {1'b1, 16'h0000})
      $display("FAIL b2b_rd got %b/%h want 1/0000", b32.io_rd_valid, b32.io_rd_addr); else passCnt++;
    cyc; b32.io_rd_resp_valid = 1'b1; b32.io_rd_resp_data = 32'h00000000;
    cyc; b32.io_rd_resp_valid = 1'b0;
    totalCnt++; if (b32.io_wr_data !== 32'h0000005C) $display("FAIL b2b_wr_data got %h want 0000005c", b32.io_wr_data); else passCnt++;
    cyc;
    totalCnt++; if ({b32.store_done, b32.store_error} !== 2'b10) $display("FAIL b2b_done got %b want 10", {b32.store_done, b32.store_error}); else passCnt++;
    cyc;
  endtask

  task automatic test_errors;
    logic sawBus;
    sawBus = 1'b0;
    cyc; b32.store_req_valid = 1'b1; b32.store_minor_opcode = 4'd1; b32.store_addr = 16'h0003; b32.store_data = 32'h00001234;
    cyc; b32.store_req_valid = 1'b0; sawBus |= b32.io_rd_valid | b32.io_wr_valid;
    totalCnt++; if ({b32.store_done, b32.store_error} !== 2'b11) $display("FAIL misalign_err got %b want 11", {b32.store_done, b32.store_error}); else passCnt++;
    cyc; sawBus |= b32.io_rd_valid | b32.io_wr_valid;
    totalCnt++; if ({b32.store_done, b32.store_req_ready} !== 2'b01) $display("FAIL misalign_idle got %b want 01", {b32.store_done, b32.store_req_ready}); else passCnt++;
    b32.store_req_valid = 1'b1; b32.store_minor_opcode = 4'd3; b32.store_addr = 16'h0000; b32.store_data = 32'hFFFFFFFF;
    cyc; b32.store_req_valid = 1'b0; sawBus |= b32.io_rd_valid | b32.io_wr_valid;
    totalCnt++; if ({b32.store_done, b32.store_error} !== 2'b11) $display("FAIL oversize_err got %b want 11", {b32.store_done, b32.store_error}); else passCnt++;
    cyc; sawBus |= b32.io_rd_valid | b32.io_wr_valid;
    totalCnt++; if ({b32.store_done, b32.store_error, b32.store_req_ready} !== 3'b001)
      $display("FAIL oversize_idle got %b want 001", {b32.store_done, b32.store_error, b32.store_req_ready}); else passCnt++;
    totalCnt++; if (sawBus !== 1'b0) $display("FAIL err_no_bus got %b want 0", sawBus); else passCnt++;
  endtask

  task automatic test_stall_64;
    b64.io_rd_ready = 1'b0; b64.io_wr_ready = 1'b0;
    cyc; b64.store_req_valid = 1'b1; b64.store_minor_opcode = 4'd2; b64.store_addr = 16'h000C; b64.store_data = 64'h0000000012345678;
    cyc; b64.store_req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      totalCnt++; if ({b64.io_rd_valid, b64.io_rd_addr} !== {1'b1, 16'h0008})
        $display("FAIL stall_rd_hold c%0d got %b/%h want 1/0008", c, b64.io_rd_valid, b64.io_rd_addr); else passCnt++;
      if (c == 2) begin b64.io_rd_resp_valid = 1'b1; b64.io_rd_resp_data = 64'hFFFFFFFFFFFFFFFF; end
      if (c == 3) b64.io_rd_resp_valid = 1'b0;
      cyc;
    end
    totalCnt++; if ({b64.io_rd_valid, b64.io_rd_addr} !== {1'b1, 16'h0008})
      $display("FAIL stall_rd_c4 got %b/%h want 1/0008", b64.io_rd_valid, b64.io_rd_addr); else passCnt++;
    b64.io_rd_ready = 1'b1;
    cyc; b64.io_rd_ready = 1'b0;
    totalCnt++; if ({b64.io_rd_valid, b64.io_wr_valid} !== 2'b00) $display("FAIL stall_rd_drop got %b want 00", {b64.io_rd_valid, b64.io_wr_valid}); else passCnt++;
    b64.io_rd_resp_valid = 1'b1; b64.io_rd_resp_data = 64'h0011223344556677;
    cyc; b64.io_rd_resp_valid = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      totalCnt++; if ({b64.io_wr_valid, b64.io_wr_addr, b64.io_wr_data, b64.store_done} !== {1'b1, 16'h0008, 64'h1234567844556677, 1'b0})
        $display("FAIL stall_wr_hold c%0d got %b/%h/%h/%b want 1/0008/1234567844556677/0", c, b64.io_wr_valid, b64.io_wr_addr, b64.io_wr_data, b64.store_done); else passCnt++;
      if (c == 9) b64.io_wr_ready = 1'b1;
      cyc;
    end
    b64.io_wr_ready = 1'b0;
    totalCnt++; if ({b64.store_done, b64.store_error, b64.io_wr_valid} !== 3'b100)
      $display("FAIL stall_done_c10 got %b want 100", {b64.store_done, b64.store_error, b64.io_wr_valid}); else passCnt++;
    cyc;
    totalCnt++; if ({b64.store_done, b64.store_req_ready} !== 2'b01) $display("FAIL stall_idle got %b want 01", {b64.store_done, b64.store_req_ready}); else passCnt++;
  endtask

  task automatic test_fullwidth_16;
    b16.io_rd_ready = 1'b1; b16.io_wr_ready = 1'b1;
    cyc; b16.store_req_valid = 1'b1; b16.store_minor_opcode = 4'd1; b16.store_addr = 16'h0010; b16.store_data = 16'h5A5A;
    cyc; b16.store_req_valid = 1'b0;
`ifdef IO_STORE_FULLWIDTH_BYPASS_EN
    totalCnt++; if ({b16.io_rd_valid, b16.io_wr_valid, b16.io_wr_addr, b16.io_wr_data} !== {2'b01, 16'h0010, 16'h5A5A})
      $display("FAIL full_bypass_wr got %b/%b/%h/%h want 0/1/0010/5a5a", b16.io_rd_valid, b16.io_wr_valid, b16.io_wr_addr, b16.io_wr_data); else passCnt++;
    cyc;
    totalCnt++; if ({b16.store_done, b16.store_error} !== 2'b10) $display("FAIL full_bypass_done got %b want 10", {b16.store_done, b16.store_error}); else passCnt++;
`else
    totalCnt++; if ({b16.io_rd_valid, b16.io_rd_addr} !== {1'b1, 16'h0010})
      $display("FAIL full_rd got %b/%h want 1/0010", b16.io_rd_valid, b16.io_rd_addr); else passCnt++;
    cyc; b16.io_rd_resp_valid = 1'b1; b16.io_rd_resp_data = 16'hFFFF;
    cyc; b16.io_rd_resp_valid = 1'b0;
    totalCnt++; if ({b16.io_wr_valid, b16.io_wr_addr, b16.io_wr_data} !== {1'b1, 16'h0010, 16'h5A5A})
      $display("FAIL full_wr got %b/%h/%h want 1/0010/5a5a", b16.io_wr_valid, b16.io_wr_addr, b16.io_wr_data); else passCnt++;
    cyc;
    totalCnt++; if ({b16.store_done, b16.store_error} !== 2'b10) $display("FAIL full_done got %b want 10", {b16.store_done, b16.store_error}); else passCnt++;
`endif
    cyc;
    totalCnt++; if ({b16.store_done, b16.store_req_ready} !== 2'b01) $display("FAIL full_idle got %b want 01", {b16.store_done, b16.store_req_ready}); else passCnt++;
  endtask

  task automatic test_reset_midop;
    cyc; b32.store_req_valid = 1'b1; b32.store_minor_opcode = 4'd0; b32.store_addr = 16'h0021; b32.store_data = 32'h00000077;
    cyc; b32.store_req_valid = 1'b0;
    totalCnt++; if ({b32.io_rd_valid, b32.io_rd_addr} !== {1'b1, 16'h0020}) $display("FAIL rst_pre_rd got %b/%h want 1/0020", b32.io_rd_valid, b32.io_rd_addr); else passCnt++;
    cyc;
    rst_n = 1'b0;
    #1;
    totalCnt++; if ({b32.store_req_ready, b32.io_rd_valid, b32.io_wr_valid, b32.store_done, b32.store_error} !== 5'b10000)
      $display("FAIL rst_async_ctrl got %b want 10000", {b32.store_req_ready, b32.io_rd_valid, b32.io_wr_valid, b32.store_done, b32.store_error}); else passCnt++;
    totalCnt++; if ({b32.io_rd_addr, b32.io_wr_addr, b32.io_wr_data} !== 64'h0)
      $display("FAIL rst_async_data got %h want 0", {b32.io_rd_addr, b32.io_wr_addr, b32.io_wr_data}); else passCnt++;
    #2 rst_n = 1'b1;
    cyc; b32.io_rd_resp_valid = 1'b1; b32.io_rd_resp_data = 32'hDEADBEEF;
    cyc; b32.io_rd_resp_valid = 1'b0;
    totalCnt++; if ({b32.io_wr_valid, b32.store_done, b32.store_req_ready} !== 3'b001)
      $display("FAIL rst_stale_ign got %b want 001", {b32.io_wr_valid, b32.store_done, b32.store_req_ready}); else passCnt++;
    cyc;
    totalCnt++; if ({b32.io_wr_valid, b32.store_done} !== 2'b00) $display("FAIL rst_no_done got %b want 00", {b32.io_wr_valid, b32.store_done}); else passCnt++;
    b32.store_req_valid = 1'b1;
    cyc; b32.store_req_valid = 1'b0;
    totalCnt++; if (b32.io_rd_valid !== 1'b1) $display("FAIL rst_next_rd got %b want 1", b32.io_rd_valid); else passCnt++;
    cyc; b32.io_rd_resp_valid = 1'b1; b32.io_rd_resp_data = 32'hAABBCCDD;
    cyc; b32.io_rd_resp_valid = 1'b0;
    totalCnt++; if ({b32.io_wr_addr, b32.io_wr_data} !== {16'h0020, 32'hAABB77DD})
      $display("FAIL rst_next_wr got %h/%h want 0020/aabb77dd", b32.io_wr_addr, b32.io_wr_data); else passCnt++;
    cyc;
    totalCnt++; if ({b32.store_done, b32.store_error} !== 2'b10) $display("FAIL rst_next_done got %b want 10", {b32.store_done, b32.store_error}); else passCnt++;
    cyc;
  endtask

  initial begin
    b32.store_req_valid = 1'b0; b32.store_minor_opcode = '0; b32.store_addr = '0; b32.store_data = '0;
    b32.io_rd_ready = 1'b0; b32.io_rd_resp_valid = 1'b0; b32.io_rd_resp_data = '0; b32.io_wr_ready = 1'b0;
    b64.store_req_valid = 1'b0; b64.store_minor_opcode = '0; b64.store_addr = '0; b64.store_data = '0;
    b64.io_rd_ready = 1'b0; b64.io_rd_resp_valid = 1'b0; b64.io_rd_resp_data = '0; b64.io_wr_ready = 1'b0;
    b16.store_req_valid = 1'b0; b16.store_minor_opcode = '0; b16.store_addr = '0; b16.store_data = '0;
    b16.io_rd_ready = 1'b0; b16.io_rd_resp_valid = 1'b0; b16.io_rd_resp_data = '0; b16.io_wr_ready = 1'b0;
    test_reset;
    test_byte_rmw;
    test_word_back_to_back;
    test_errors;
    test_stall_64;
    test_fullwidth_16;
    test_reset_midop;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/io_store_rmw_unit.md
# io_store_rmw_unit

Sequential read-modify-write engine for sub-word stores to the IO bus, parametrised over data width. It accepts one store request at a time and checks that the store is aligned and fits the bus. It then reads the containing bus word, merges the store bytes into it and writes the merged word back. It reports completion or error to the load/store pipeline.

## Interface
Parameters:
- DATABITWIDTH, 16: bus/data width in bits; legal values 8, 16, 32, 64.
- ADDRBITWIDTH, 16: byte-address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- store_req_valid  in  1  store request present.
- store_req_ready  out  1  unit can accept a request.
- store_minor_opcode  in  4  bits [1:0] give the size code (0 byte, 1 word 16b, 2 double 32b, 3 quad 64b); bits [3:2] are ignored.
- store_addr  in  ADDRBITWIDTH  byte address.
- store_data  in  DATABITWIDTH  store value, right-justified.
- io_rd_valid / io_rd_ready  out/in  1  read request handshake.
- io_rd_addr  out  ADDRBITWIDTH  word-aligned read address.
- io_rd_resp_valid  in  1  read data valid.
- io_rd_resp_data  in  DATABITWIDTH  read data.
- io_wr_valid / io_wr_ready  out/in  1  write request handshake.
- io_wr_addr  out  ADDRBITWIDTH  word-aligned write address.
- io_wr_data  out  DATABITWIDTH  merged word.
- store_done  out  1  one-cycle completion pulse.
- store_error  out  1  qualifies store_done: the request was rejected.

## Operation
- Derived values:
  - OFFW = log2(DATABITWIDTH/8); OFFW is 0 for an 8-bit bus.
  - Word address = store_addr with its low OFFW bits cleared.
  - Byte offset = store_addr[OFFW-1:0].
  - Size bytes = 1 << size code.
- Request checks, in priority order:
  - Error if size bytes > DATABITWIDTH/8.
  - Otherwise, error if the byte offset is not a multiple of size bytes (misaligned).
  - An errored request makes no bus access.
- Merge rule: the merged word equals io_rd_resp_data, except bytes [offset, offset+size-1], which take store_data[size*8-1:0].
- FSM states:
  - IDLE: store_req_ready=1. On accept, capture opcode, address and data. Go to ERR if the request is illegal, to WR if it is bypass-eligible (see Configuration), otherwise to RD_REQ.
  - RD_REQ: io_rd_valid=1 with io_rd_addr = word address. On io_rd_ready, go to RD_WAIT.
  - RD_WAIT: wait for io_rd_resp_valid. On it, register the merged word and go to WR. io_rd_resp_valid is ignored in every other state.
  - WR: io_wr_valid=1 with io_wr_addr and io_wr_data held stable until io_wr_ready. On io_wr_ready, go to DONE.
  - DONE: store_done=1, store_error=0, then IDLE.
  - ERR: store_done=1, store_error=1, then IDLE.
- Exactly one request is in flight. store_req_ready is 0 in every state except IDLE.

## Timing
- Reset values: state IDLE, store_req_ready=1, and io_rd_valid, io_wr_valid, store_done and store_error all 0. Address and data outputs reset to 0.
- Reset asserted mid-operation: return to IDLE immediately. The in-flight request is dropped with no done pulse, and any pending bus valid drops asynchronously.
- All outputs are registered state decodes. No combinational path from any input to any output.
- Zero-wait RMW: accept at edge 0, io_rd_valid in cycle 1, response earliest cycle 2, io_wr_valid cycle 3, store_done cycle 4.
- Each extra ready or response wait cycle adds one cycle.
- Error path: accept at edge 0, store_done with store_error in cycle 1.
- Back-to-back requests: the next accept can happen in the cycle after store_done.
- Valid-before-ready bus rule: valids are never withdrawn before their handshake, and addr/data are held stable while valid.

## Configuration
- IO_STORE_FULLWIDTH_BYPASS_EN defined: a legal store whose size bytes equal DATABITWIDTH/8 skips the read. It goes IDLE→WR with io_wr_data = store_data. Zero-wait latency is accept to store_done in 2 cycles.
- Macro undefined: every legal store, full-width included, takes the RMW path. A full-width merge equals store_data.

## Test plan
- DATABITWIDTH=32, byte store addr 0x0006, data 0xAB, read returns 0x11223344 → io_rd_addr 0x0004, io_wr_data 0x11AB3344, store_done at cycle 4, store_error 0.
- DATABITWIDTH=32, word store addr 0x0002, data 0xBEEF, read 0xCAFEF00D → io_wr_data 0xBEEFF00D.
- DATABITWIDTH=32, word store at addr 0x0003 and separately quad store at addr 0x0000 → store_done with store_error in cycle 1 each time; io_rd_valid and io_wr_valid never asserted.
- DATABITWIDTH=64, double store addr 0x000C data 0x12345678, io_rd_ready and io_wr_ready each held low 3 cycles → addr/data stable throughout, io_wr_data upper half 0x12345678, store_done at cycle 10.
- DATABITWIDTH=16, word store addr 0x0010 data 0x5A5A → with the macro defined: no read, write at cycle 1, done at cycle 2; without it: read issued, io_wr_data 0x5A5A, done at cycle 4.
- rst_n pulsed low while in RD_WAIT, then a stale io_rd_resp_valid arrives → outputs are at reset values, the response is ignored, no store_done, and the next request completes normally.
